if_id_skid_reg: RTL

- Pipeline register between the instruction-fetch stage and the decode stage of the 16-bit pipelined processor.
- Captures each fetched instruction and its NPC (PC+2) and presents them to decode with a valid/ready handshake.
- Holds a second "skid" entry so fetch sees a registered ready. This avoids a combinational path from decode stall to fetch.
- A flush input discards all held instructions on a taken jump, branch or return.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/if_id_skid_reg_pipe_entry.sv | 62 ++++++
 rtl/if_id_skid_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the IF/ID/EX stages of the 16-bit pipelined processor:
//   - instruction and address widths
//   - the NOP encoding decode sees when no instruction is valid
//   - the occupancy state encoding used by the IF/ID skid register
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // Occupancy of the two-entry IF/ID register.
    //   EMPTY: nothing held
    //   ONE  : main entry valid, skid entry empty
    //   FULL : main and skid entries both valid (fetch is stalled)
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } ifid_state_e;

endpackage : pipeline_pkg

// File: rtl/if_id_skid_reg_pipe_entry.sv
// ----------------------------------------------------------------------------
// pipe_entry
// One pipeline slot: a valid bit plus an instruction and its NPC.
//   load  : capture instr_i/npc_i and mark the slot valid
//   clear : mark the slot invalid (data is left as-is; consumers gate on valid)
// Clear wins if both are asserted.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (slot empty, data 0)
//   load_i, clear_i slot control
//   instr_i, npc_i  data to capture on load
//   valid_o         slot holds an entry
//   instr_o, npc_o  captured data
// ----------------------------------------------------------------------------
module pipe_entry #(
    parameter int unsigned IW = 16,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [IW-1:0] instr_i,
    input  logic [AW-1:0] npc_i,
    output logic          valid_o,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] npc_o
);

    logic          valid_q, valid_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] npc_q,   npc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            npc_d   = npc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            npc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign npc_o   = npc_q;

endmodule : pipe_entry

// File: rtl/if_id_skid_reg.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline register with a one-deep skid buffer. Fetch sees a registered
// in_ready, so a decode stall never reaches fetch combinationally; the skid
// slot absorbs the one instruction fetch may already have launched.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush                         drop every held entry (taken jump/branch/ret)
//   in_valid, in_instr, in_npc    fetch side request
//   in_ready                      registered; low only while the skid is full
//   out_valid, out_instr, out_npc decode side; oldest entry, NOP/0 when empty
//   out_ready                     decode consumes the presented entry
// ----------------------------------------------------------------------------
module if_id_skid_reg #(
    parameter int unsigned      IW        = pipeline_pkg::INSTR_W,
    parameter int unsigned      AW        = pipeline_pkg::ADDR_W,
    parameter logic [IW-1:0]    NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_npc,
    output logic          in_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_npc,
    input  logic          out_ready
);

    import pipeline_pkg::*;

    ifid_state_e state_q, state_d;
    logic        in_ready_q, in_ready_d;

    logic          accept, consume;
    logic          main_ld, main_clr, main_from_skid;
    logic          skid_ld, skid_clr;
    logic [IW-1:0] main_din_instr;
    logic [AW-1:0] main_din_npc;

    logic          main_vld, skid_vld;
    logic [IW-1:0] main_instr, skid_instr;
    logic [AW-1:0] main_npc,   skid_npc;

    assign accept  = in_valid & in_ready_q;
    assign consume = main_vld & out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM. Flush overrides everything except that a consume in
    // the same cycle has already been seen by decode, so nothing extra is
    // needed for it: the entry is simply cleared along with the rest.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = FULL;
                    end else if (consume) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid refills main.
                    if (consume) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // in_ready tracks the *next* skid occupancy so it is a clean flop output.
    assign in_ready_d = (state_d != FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign main_din_instr = main_from_skid ? skid_instr : in_instr;
    assign main_din_npc   = main_from_skid ? skid_npc   : in_npc;

    pipe_entry #(.IW(IW), .AW(AW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_ld),
        .clear_i (main_clr),
        .instr_i (main_din_instr),
        .npc_i   (main_din_npc),
        .valid_o (main_vld),
        .instr_o (main_instr),
        .npc_o   (main_npc)
    );

    pipe_entry #(.IW(IW), .AW(AW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_ld),
        .clear_i (skid_clr),
        .instr_i (in_instr),
        .npc_i   (in_npc),
        .valid_o (skid_vld),
        .instr_o (skid_instr),
        .npc_o   (skid_npc)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    // Stale data stays in the slot after clear/flush; mask it here.
    assign out_instr = main_vld ? main_instr : NOP_INSTR;
    assign out_npc   = main_vld ? main_npc   : '0;

    // skid_vld is implied by state_q; kept for readability of the datapath.
    logic unused_skid_vld;
    assign unused_skid_vld = skid_vld;

endmodule : if_id_skid_reg
